ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Synchronous front-end sequencing read/write requests into the 8x8 tri-state RAM.
//  - Converts a valid/ready request port into the RAM's level-sensitive sel/op/adr/inp pulse protocol.
//  - Captures read data from the RAM's tri-stated outp and returns it on a one-cycle response strobe.
//  - Sits directly upstream of the RAM; its ram_* ports connect 1:1 to the RAM's ports.
// PARAMETERS
//  DATA_W   8   data width (RAM word width)
//  ADDR_W   3   address width (2**ADDR_W locations)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, asynchronous, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept a request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       one-cycle strobe: rsp_rdata holds read result
//  rsp_rdata  out  DATA_W  last read data
//  busy       out  1       controller not idle
//  ram_sel    out  1       to RAM sel
//  ram_op     out  1       to RAM op (1 = write)
//  ram_adr    out  ADDR_W  to RAM adr
//  ram_inp    out  DATA_W  to RAM inp
//  ram_outp   in   DATA_W  from RAM outp; high-Z whenever ram_sel = 0
// BEHAVIOUR
//  - Reset (async, rst_n = 0): all outputs 0, except req_ready = 1 when RAM_CTRL_INIT_EN is undefined.
//    FSM goes to IDLE (INIT_SETUP when the macro is defined). ram_sel drops immediately.
//    A write in flight is aborted; the content at that address is then undefined.
//  - All outputs are registered; ram_* change only on clk rising edges.
//  - FSM: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE.
//    - IDLE: req_ready = 1. On req_valid & req_ready, latch we/addr/wdata into ram_op/ram_adr/ram_inp,
//      then go to SETUP.
//    - SETUP: ram_sel = 0; address, op and data are stable at the RAM (1 cycle).
//    - ACCESS: ram_sel = 1 for exactly 1 cycle; ram_op/adr/inp held.
//      For a read, ram_outp is registered into rsp_rdata on the edge leaving ACCESS.
//    - RECOVER: ram_sel = 0; ram_op/adr/inp held (1 cycle).
//      For a read, rsp_valid = 1 for this cycle only; writes never assert rsp_valid.
//  - req_ready = 1 only in IDLE; the request is accepted on the edge where valid & ready.
//    req_* are ignored in every other state; no queueing.
//  - busy = (state != IDLE).
//  - Timing: accept at edge E -> ram_sel high during E+1..E+2 -> rsp_valid high during E+2..E+3.
//    Throughput is at most one request per 4 cycles.
//  - rsp_rdata holds its value until the next read captures; writes do not modify it.
//  - ram_outp is sampled only in ACCESS; Z/X at any other time is ignored.
//  - Write then read of the same address, back-to-back, returns the new data (no bypass needed).
//  - Address wrap: no arithmetic on req_addr; all 2**ADDR_W addresses are legal.
// CONFIGURATION
//  - RAM_CTRL_INIT_EN defined:
//    - After reset deassertion, the FSM runs INIT_SETUP/INIT_ACCESS/INIT_RECOVER for addresses
//      0..2**ADDR_W-1, writing 0 to each with the same 3-cycle pulse shape.
//    - During init: req_ready = 0, busy = 1, rsp_valid = 0. Total 24 cycles at default parameters.
//    - Ends in IDLE with ram_adr = 0, ram_op = 0, ram_inp = 0.
//  - RAM_CTRL_INIT_EN undefined: no init states; the FSM starts in IDLE; RAM content after reset
//    is undefined.
// TESTING
//  1. Write 0xAA to addr 1, then read addr 1.
//     -> ram_sel pulses 1 cycle each; read yields rsp_valid 1 cycle with rsp_rdata = 0xAA,
//        2 cycles after acceptance.
//  2. Write 0xCC@2, 0xF0@3, 0x0F@4, 0x33@5, 0x55@6, 0x99@7, then read 7..2.
//     -> each read returns its written value; rsp_rdata unchanged across the writes.
//  3. Hold req_valid high continuously with alternating requests.
//     -> req_ready high only 1 of every 4 cycles; no request lost or duplicated;
//        ram_sel never high 2 consecutive cycles.
//  4. Assert rst_n = 0 during ACCESS of a write.
//     -> ram_sel, rsp_valid and busy go 0 immediately (before the next edge);
//        after release, req_ready = 1 (or the init sequence starts).
//  5. With RAM_CTRL_INIT_EN: release reset, then read every address.
//     -> req_ready = 0 for 24 cycles; all reads return 0x00.
//  6. Read while RAM outp is Z outside ACCESS (tri-state model).
//     -> rsp_rdata never shows Z/X after a completed read of a written address.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front-end driving the 8x8 tri-state RAM sel/op/adr/inp pulse protocol; define RAM_CTRL_INIT_EN to zero-fill the RAM after reset
module ram_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_sel,
  output logic              ram_op,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_inp,
  input  logic [DATA_W-1:0] ram_outp
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] RECOVER = 3'd3;
`ifdef RAM_CTRL_INIT_EN
  localparam logic [2:0] INIT_SETUP   = 3'd4;
  localparam logic [2:0] INIT_ACCESS  = 3'd5;
  localparam logic [2:0] INIT_RECOVER = 3'd6;
  localparam logic [2:0] RST_STATE    = INIT_SETUP;
  localparam logic       RST_READY    = 1'b0;
`else
  localparam logic [2:0] RST_STATE    = IDLE;
  localparam logic       RST_READY    = 1'b1;
`endif

  logic [2:0] state, nxt;

  // next-state: one request walks SETUP/ACCESS/RECOVER; init walks every address once
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = req_valid ? SETUP : IDLE;
      SETUP:        nxt = ACCESS;
      ACCESS:       nxt = RECOVER;
      RECOVER:      nxt = IDLE;
`ifdef RAM_CTRL_INIT_EN
      INIT_SETUP:   nxt = INIT_ACCESS;
      INIT_ACCESS:  nxt = INIT_RECOVER;
      INIT_RECOVER: nxt = (&ram_adr) ? IDLE : INIT_SETUP;
`endif
      default:      nxt = IDLE;
    endcase
  end

  // state and all outputs registered from the next state so ram_* only move on clk edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      req_ready <= RST_READY;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_sel   <= 1'b0;
      ram_op    <= 1'b0;
      ram_adr   <= '0;
      ram_inp   <= '0;
    end else begin
      state     <= nxt;
      req_ready <= nxt == IDLE;
      busy      <= nxt != IDLE;
      rsp_valid <= state == ACCESS && !ram_op;
`ifdef RAM_CTRL_INIT_EN
      ram_sel   <= nxt == ACCESS || nxt == INIT_ACCESS;
`else
      ram_sel   <= nxt == ACCESS;
`endif
      if (state == IDLE && req_valid) begin
        ram_op  <= req_we;
        ram_adr <= req_addr;
        ram_inp <= req_wdata;
      end
      if (state == ACCESS && !ram_op)
        rsp_rdata <= ram_outp;
`ifdef RAM_CTRL_INIT_EN
      if (state == INIT_SETUP)
        ram_op <= 1'b1;
      if (state == INIT_RECOVER) begin
        ram_op  <= !(&ram_adr);
        ram_adr <= (&ram_adr) ? '0 : ram_adr + ADDR_W'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed vector bench for ram_access_ctrl against a tri-state RAM model
module tb_ram_access_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       req_valid = 0;
  logic       req_ready;
  logic       req_we = 0;
  logic [2:0] req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       ram_sel;
  logic       ram_op;
  logic [2:0] ram_adr;
  logic [7:0] ram_inp;
  wire  [7:0] ram_outp;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_rd = 0;

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .ram_sel(ram_sel), .ram_op(ram_op), .ram_adr(ram_adr), .ram_inp(ram_inp),
    .ram_outp(ram_outp)
  );

  // RAM model: writes on a clock edge while selected, drives outp only while selected
  logic [7:0] mem [8];
  always @(posedge clk) if (ram_sel && ram_op) mem[ram_adr] <= ram_inp;
  assign ram_outp = ram_sel ? mem[ram_adr] : 8'bz;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] addr, input logic [7:0] wdata, input logic [7:0] exp);
    int t = 0;
    while (!req_ready && t < 40) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_wait", req_ready, 1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    chk("setup_ready", req_ready, 0);
    chk("setup_busy", busy, 1);
    chk("setup_sel", ram_sel, 0);
    chk("setup_adr", {ram_op, ram_adr}, {we, addr});
    if (we) chk("setup_inp", ram_inp, wdata);
    @(posedge clk); #1;
    chk("access_sel", ram_sel, 1);
    chk("access_hold", {ram_op, ram_adr}, {we, addr});
    chk("access_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    chk("recover_sel", ram_sel, 0);
    chk("recover_rsp", rsp_valid, !we);
    if (!we) last_rd = exp;
    chk("rdata", rsp_rdata, last_rd);
    chk("rdata_known", $isunknown(rsp_rdata), 0);
    @(posedge clk); #1;
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  logic [7:0] s_wd [4] = '{8'h11, 8'h00, 8'h22, 8'h00};
  logic       s_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] s_ex [2] = '{8'h11, 8'h22};

  initial begin
    vecs[0]  = '{1, 3'd1, 8'hAA, 8'h00};
    vecs[1]  = '{0, 3'd1, 8'h00, 8'hAA};
    vecs[2]  = '{1, 3'd2, 8'hCC, 8'h00};
    vecs[3]  = '{1, 3'd3, 8'hF0, 8'h00};
    vecs[4]  = '{1, 3'd4, 8'h0F, 8'h00};
    vecs[5]  = '{1, 3'd5, 8'h33, 8'h00};
    vecs[6]  = '{1, 3'd6, 8'h55, 8'h00};
    vecs[7]  = '{1, 3'd7, 8'h99, 8'h00};
    vecs[8]  = '{0, 3'd7, 8'h00, 8'h99};
    vecs[9]  = '{0, 3'd6, 8'h00, 8'h55};
    vecs[10] = '{0, 3'd5, 8'h00, 8'h33};
    vecs[11] = '{0, 3'd4, 8'h00, 8'h0F};
    vecs[12] = '{0, 3'd3, 8'h00, 8'hF0};
    vecs[13] = '{0, 3'd2, 8'h00, 8'hCC};
    vecs[14] = '{1, 3'd0, 8'h5A, 8'h00};
    vecs[15] = '{0, 3'd0, 8'h00, 8'h5A};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_sel", ram_sel, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_bus", {ram_op, ram_adr, ram_inp, rsp_rdata}, 0);
`ifdef RAM_CTRL_INIT_EN
    chk("rst_ready", req_ready, 0);
`else
    chk("rst_ready", req_ready, 1);
`endif
    @(negedge clk); rst_n = 1;

`ifdef RAM_CTRL_INIT_EN
    begin
      int n = 0;
      while (n < 40) begin
        @(posedge clk); #1; n++;
        if (req_ready) break;
        chk("init_busy", busy, 1);
        chk("init_rsp", rsp_valid, 0);
      end
      chk("init_len", n, 24);
      chk("init_end", {ram_op, ram_adr, ram_inp}, 0);
      for (int a = 0; a < 8; a++) do_req(0, 3'(a), 8'h00, 8'h00);
    end
`else
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 16; i++) do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // continuous valid with alternating write/read
    begin
      int k = 0, cyc = 0, last_acc = 0, rd = 0, n_rdy = 0;
      logic acc, prev_sel = 0;
      req_valid = 1; req_we = s_we[0]; req_addr = 3'd0; req_wdata = s_wd[0];
      for (int c = 0; c < 20; c++) begin
        acc = req_ready && req_valid;
        @(posedge clk); #1; cyc++;
        chk("sel_gap", ram_sel & prev_sel, 0);
        prev_sel = ram_sel;
        if (rsp_valid) begin
          chk("stream_rdata", rsp_rdata, (rd < 2) ? s_ex[rd] : 8'hxx);
          rd++;
        end
        if (acc) begin
          n_rdy++;
          if (k > 0) chk("accept_gap", cyc - last_acc, 4);
          last_acc = cyc; k++;
          if (k < 4) begin
            req_we = s_we[k]; req_wdata = s_wd[k];
          end else req_valid = 0;
        end
      end
      chk("stream_accepts", n_rdy, 4);
      chk("stream_reads", rd, 2);
      last_rd = 8'h22;
    end

    // async reset during ACCESS of a write
    req_valid = 1; req_we = 1; req_addr = 3'd3; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("abort_sel_pre", ram_sel, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_sel", ram_sel, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_busy", busy, 0);
`ifdef RAM_CTRL_INIT_EN
    chk("abort_ready", req_ready, 0);
`else
    chk("abort_ready", req_ready, 1);
`endif
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    last_rd = 0;
    do_req(1, 3'd3, 8'h3C, 8'h00);
    do_req(0, 3'd3, 8'h00, 8'h3C);
    do_req(0, 3'd7, 8'h00, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
